operand_fetch: RTL and testbench
================================

Name: operand_fetch

Overview:
- Issue-side consumer of the register file: takes decoded instructions over a valid/ready handshake and drives the register file read selects.
- Collects both source operands, bypassing same-cycle writeback data.
- Tracks in-flight destination registers in a 32-entry scoreboard and stalls on RAW/WAW hazards.
- Presents operands to execute through a one-entry registered output stage with valid/ready.

Parameters:
- XLEN, 32, register/operand width.
- PAYLOAD_W, 32, opaque per-instruction sideband (PC, opcode fields) passed through unchanged.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  instruction accepted this cycle when in_valid && in_ready.
- in_rs1, in_rs2  in  5  source register indices.
- in_use_rs1, in_use_rs2  in  1  source actually read (gates hazard check).
- in_rd  in  5  destination index.
- in_rd_wen  in  1  instruction writes in_rd.
- in_payload  in  PAYLOAD_W  sideband.
- rf_rsel1, rf_rsel2  out  5  register file read selects = in_rs1/in_rs2 (combinational).
- rf_rdata1, rf_rdata2  in  XLEN  register file read data (combinational, same cycle).
- wb_valid  in  1  writeback retiring this cycle; also writes the register file.
- wb_sel  in  5  writeback register index.
- wb_data  in  XLEN  writeback data.
- out_valid  out  1  operand bundle valid.
- out_ready  in  1  execute consumes bundle.
- out_op1, out_op2  out  XLEN  resolved operands.
- out_rd, out_rd_wen, out_payload  out  5/1/PAYLOAD_W  forwarded fields.
- busy  out  1  OR of all scoreboard bits.

Behaviour:
- Reset (rst=0, async): scoreboard = 0, out_valid = 0, out_op1/op2/rd/rd_wen/payload = 0, busy = 0. Reset mid-operation drops the held bundle and all reservations.
- Scoreboard: 32 bits, bit 0 hardwired 0.
  - Set on accept when in_rd_wen && in_rd != 0.
  - Clear when wb_valid && wb_sel != 0.
  - Same-cycle set and clear of the same index: set wins (new reservation).
- Hazard for source s (rs1/rs2): in_use_s && rs_s != 0 && sb[rs_s] && !(wb_valid && wb_sel == rs_s).
- WAW hazard: in_rd_wen && in_rd != 0 && sb[in_rd] && !(wb_valid && wb_sel == in_rd).
- in_ready = (!out_valid || out_ready) && !any_hazard. Depends on register fields and scoreboard, never on in_valid.
- Operand select per source:
  - rs == 0 or !in_use: 0.
  - Else wb_valid && wb_sel == rs: wb_data (bypass; the register file write is not yet visible).
  - Else rf_rdata.
- Accept: on the rising edge with in_valid && in_ready, the output stage loads operands/rd/rd_wen/payload and out_valid <= 1. Latency is 1 cycle from accept to out_valid.
- Output stage:
  - out_valid && out_ready with no new accept: out_valid <= 0.
  - Consume and accept in the same cycle: back-to-back, out_valid stays 1 with the new bundle.
  - out_valid && !out_ready: all outputs hold stable and in_ready = 0.
- wb_valid with wb_sel == 0: ignored (no clear, no bypass).
- wb_valid for an unreserved register: clear is a no-op and bypass still applies.

Test Plan:
- Reset: hold rst=0 with in_valid=1 -> out_valid=0, in_ready stays 0 only if out_valid, busy=0; release rst -> first instruction (rs1=1, rs2=2, rf_rdata=0x11/0x22) gives out_op1=0x11, out_op2=0x22 one cycle after accept.
- RAW stall: accept rd=5 wen; next instr rs1=5 -> in_ready=0 for 3 cycles; then wb_valid, wb_sel=5, wb_data=0xDEADBEEF -> same-cycle accept, out_op1=0xDEADBEEF, sb[5] cleared, busy=0.
- x0: rd=0 wen=1 -> no reservation, busy=0; rs1=0 with rf_rdata1=0xFFFFFFFF -> out_op1=0.
- WAW with set/clear collision: rd=7 in flight; new instr rd=7 arrives while wb_sel=7 -> accepted, sb[7] remains 1, busy=1.
- Backpressure: out_ready=0 for 4 cycles with in_valid=1 -> out_* stable and in_ready=0; out_ready=1 -> back-to-back accept, out_valid stays 1, new payload appears next edge.
- Async reset mid-stall: assert rst=0 between clock edges while sb[3]=1 and out_valid=1 -> out_valid and busy drop immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/operand_fetch_if.sv
// Operand fetch bus: issue-side instruction handshake, register file read
// port, writeback snoop and the operand bundle handed to execute.
interface operand_fetch_if #(
    parameter int XLEN      = 32,
    parameter int PAYLOAD_W = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [4:0]           in_rs1;
    logic [4:0]           in_rs2;
    logic                 in_use_rs1;
    logic                 in_use_rs2;
    logic [4:0]           in_rd;
    logic                 in_rd_wen;
    logic [PAYLOAD_W-1:0] in_payload;

    logic [4:0]           rf_rsel1;
    logic [4:0]           rf_rsel2;
    logic [XLEN-1:0]      rf_rdata1;
    logic [XLEN-1:0]      rf_rdata2;

    logic                 wb_valid;
    logic [4:0]           wb_sel;
    logic [XLEN-1:0]      wb_data;

    logic                 out_valid;
    logic                 out_ready;
    logic [XLEN-1:0]      out_op1;
    logic [XLEN-1:0]      out_op2;
    logic [4:0]           out_rd;
    logic                 out_rd_wen;
    logic [PAYLOAD_W-1:0] out_payload;

    logic                 busy;

    // Environment side: decoder, register file, writeback and execute
    modport master (
        output in_valid, in_rs1, in_rs2, in_use_rs1, in_use_rs2, in_rd, in_rd_wen, in_payload,
        input  in_ready,
        input  rf_rsel1, rf_rsel2,
        output rf_rdata1, rf_rdata2,
        output wb_valid, wb_sel, wb_data,
        input  out_valid, out_op1, out_op2, out_rd, out_rd_wen, out_payload,
        output out_ready,
        input  busy
    );

    // Operand fetch block side
    modport slave (
        input  in_valid, in_rs1, in_rs2, in_use_rs1, in_use_rs2, in_rd, in_rd_wen, in_payload,
        output in_ready,
        output rf_rsel1, rf_rsel2,
        input  rf_rdata1, rf_rdata2,
        input  wb_valid, wb_sel, wb_data,
        output out_valid, out_op1, out_op2, out_rd, out_rd_wen, out_payload,
        input  out_ready,
        output busy
    );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch: reads both sources from the register file, bypasses the
// writeback of the same cycle, stalls on RAW/WAW against a 32-entry
// scoreboard of in-flight destinations, and registers one operand bundle.
module operand_fetch #(
    parameter int XLEN      = 32,
    parameter int PAYLOAD_W = 32
) (
    input logic           clk,
    input logic           rst,
    operand_fetch_if.slave bus
);
    logic [31:0]          sb_q, sb_d;
    logic                 wb_act, wb_hit1, wb_hit2, wb_hitd;
    logic                 hz1, hz2, hzw, ready, accept;
    logic [XLEN-1:0]      op1, op2;

    logic                 ov_q;
    logic [XLEN-1:0]      op1_q, op2_q;
    logic [4:0]           rd_q;
    logic                 wen_q;
    logic [PAYLOAD_W-1:0] pl_q;

    assign bus.rf_rsel1    = bus.in_rs1;
    assign bus.rf_rsel2    = bus.in_rs2;
    assign bus.in_ready    = ready;
    assign bus.out_valid   = ov_q;
    assign bus.out_op1     = op1_q;
    assign bus.out_op2     = op2_q;
    assign bus.out_rd      = rd_q;
    assign bus.out_rd_wen  = wen_q;
    assign bus.out_payload = pl_q;
    assign bus.busy        = |sb_q;

    // Hazard detection, operand bypass and next scoreboard
    always_comb begin
        // a writeback to x0 is ignored entirely: no clear, no bypass
        wb_act  = bus.wb_valid && (bus.wb_sel != 5'd0);
        wb_hit1 = wb_act && (bus.wb_sel == bus.in_rs1);
        wb_hit2 = wb_act && (bus.wb_sel == bus.in_rs2);
        wb_hitd = wb_act && (bus.wb_sel == bus.in_rd);

        // a retiring writeback resolves the hazard in the same cycle
        hz1 = bus.in_use_rs1 && (bus.in_rs1 != 5'd0) && sb_q[bus.in_rs1] && !wb_hit1;
        hz2 = bus.in_use_rs2 && (bus.in_rs2 != 5'd0) && sb_q[bus.in_rs2] && !wb_hit2;
        hzw = bus.in_rd_wen  && (bus.in_rd  != 5'd0) && sb_q[bus.in_rd]  && !wb_hitd;

        ready  = (!ov_q || bus.out_ready) && !(hz1 || hz2 || hzw);
        accept = bus.in_valid && ready;

        // register file write lands at the edge, so bypass wb_data now
        op1 = '0;
        if (bus.in_use_rs1 && (bus.in_rs1 != 5'd0))
            op1 = wb_hit1 ? bus.wb_data : bus.rf_rdata1;
        op2 = '0;
        if (bus.in_use_rs2 && (bus.in_rs2 != 5'd0))
            op2 = wb_hit2 ? bus.wb_data : bus.rf_rdata2;

        // clear first so a same-index new reservation wins
        sb_d = sb_q;
        if (wb_act)
            sb_d[bus.wb_sel] = 1'b0;
        if (accept && bus.in_rd_wen && (bus.in_rd != 5'd0))
            sb_d[bus.in_rd] = 1'b1;
        sb_d[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sb_q <= '0;
        else      sb_q <= sb_d;
    end

    // One-entry output stage; holds while execute back-pressures
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ov_q  <= 1'b0;
            op1_q <= '0;
            op2_q <= '0;
            rd_q  <= '0;
            wen_q <= 1'b0;
            pl_q  <= '0;
        end else if (accept) begin
            ov_q  <= 1'b1;
            op1_q <= op1;
            op2_q <= op2;
            rd_q  <= bus.in_rd;
            wen_q <= bus.in_rd_wen;
            pl_q  <= bus.in_payload;
        end else if (bus.out_ready) begin
            ov_q  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed scenarios followed by a
// randomized run against a behavioural model of scoreboard and output stage.
module tb_operand_fetch;
    logic clk;
    logic rst;
    logic [31:0] regs [32];
    int nvec;
    int nerr;

    operand_fetch_if #(.XLEN(32), .PAYLOAD_W(32)) bus ();

    operand_fetch #(.XLEN(32), .PAYLOAD_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.rf_rdata1 = regs[bus.rf_rsel1];
    assign bus.rf_rdata2 = regs[bus.rf_rsel2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one edge; register file commits the writeback after the edge
    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.wb_valid && bus.wb_sel != 5'd0) regs[bus.wb_sel] = bus.wb_data;
    endtask

    task automatic idle();
        bus.in_valid   = 1'b0;
        bus.in_rs1     = 5'd0;
        bus.in_rs2     = 5'd0;
        bus.in_use_rs1 = 1'b0;
        bus.in_use_rs2 = 1'b0;
        bus.in_rd      = 5'd0;
        bus.in_rd_wen  = 1'b0;
        bus.in_payload = 32'h0;
        bus.wb_valid   = 1'b0;
        bus.wb_sel     = 5'd0;
        bus.wb_data    = 32'h0;
        bus.out_ready  = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle();
        bus.in_valid = 1'b1; bus.in_rs1 = 5'd1; bus.in_rs2 = 5'd2;
        bus.in_use_rs1 = 1'b1; bus.in_use_rs2 = 1'b1; bus.in_payload = 32'hA1;
        tick(); tick();
        nvec++; if (bus.out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
        nvec++; if (bus.busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        nvec++; if (bus.in_ready !== 1'b1) begin nerr++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
        nvec++; if (bus.out_op1 !== 32'h0 || bus.out_payload !== 32'h0) begin nerr++; $display("FAIL reset_regs got %h/%h exp 0/0", bus.out_op1, bus.out_payload); end
        rst = 1'b1;
        #1;
        tick();
        nvec++; if (bus.out_valid !== 1'b1) begin nerr++; $display("FAIL first_valid got %b exp 1", bus.out_valid); end
        nvec++; if (bus.out_op1 !== 32'h11 || bus.out_op2 !== 32'h22) begin nerr++; $display("FAIL first_ops got %h/%h exp 11/22", bus.out_op1, bus.out_op2); end
        nvec++; if (bus.out_payload !== 32'hA1) begin nerr++; $display("FAIL first_payload got %h exp a1", bus.out_payload); end
        idle();
        tick();
        nvec++; if (bus.out_valid !== 1'b0) begin nerr++; $display("FAIL first_drain got %b exp 0", bus.out_valid); end
    endtask

    task automatic test_raw();
        idle();
        bus.in_valid = 1'b1; bus.in_rd = 5'd5; bus.in_rd_wen = 1'b1; bus.in_payload = 32'hB0;
        tick();
        nvec++; if (bus.busy !== 1'b1) begin nerr++; $display("FAIL raw_reserve got %b exp 1", bus.busy); end
        bus.in_rd = 5'd0; bus.in_rd_wen = 1'b0; bus.in_rs1 = 5'd5; bus.in_use_rs1 = 1'b1; bus.in_payload = 32'hB1;
        for (int i = 0; i < 3; i++) begin
            #1;
            nvec++; if (bus.in_ready !== 1'b0) begin nerr++; $display("FAIL raw_stall[%0d] got %b exp 0", i, bus.in_ready); end
            tick();
        end
        bus.wb_valid = 1'b1; bus.wb_sel = 5'd5; bus.wb_data = 32'hDEADBEEF;
        #1;
        nvec++; if (bus.in_ready !== 1'b1) begin nerr++; $display("FAIL raw_release got %b exp 1", bus.in_ready); end
        tick();
        nvec++; if (bus.out_valid !== 1'b1 || bus.out_op1 !== 32'hDEADBEEF) begin nerr++; $display("FAIL raw_bypass got %b/%h exp 1/deadbeef", bus.out_valid, bus.out_op1); end
        nvec++; if (bus.busy !== 1'b0) begin nerr++; $display("FAIL raw_clear got %b exp 0", bus.busy); end
        idle();
        tick();
    endtask

    task automatic test_x0();
        idle();
        regs[0] = 32'hFFFFFFFF;
        regs[3] = 32'h33333333;
        bus.in_valid = 1'b1; bus.in_rd = 5'd0; bus.in_rd_wen = 1'b1;
        bus.in_rs1 = 5'd0; bus.in_use_rs1 = 1'b1; bus.in_rs2 = 5'd3; bus.in_use_rs2 = 1'b0;
        tick();
        nvec++; if (bus.busy !== 1'b0) begin nerr++; $display("FAIL x0_reserve got %b exp 0", bus.busy); end
        nvec++; if (bus.out_op1 !== 32'h0 || bus.out_op2 !== 32'h0) begin nerr++; $display("FAIL x0_ops got %h/%h exp 0/0", bus.out_op1, bus.out_op2); end
        regs[0] = 32'h0;
        idle();
        tick();
    endtask

    task automatic test_waw();
        idle();
        bus.in_valid = 1'b1; bus.in_rd = 5'd7; bus.in_rd_wen = 1'b1; bus.in_payload = 32'hC0;
        tick();
        bus.in_payload = 32'hC1;
        bus.wb_valid = 1'b1; bus.wb_sel = 5'd7; bus.wb_data = 32'h77;
        #1;
        nvec++; if (bus.in_ready !== 1'b1) begin nerr++; $display("FAIL waw_accept got %b exp 1", bus.in_ready); end
        tick();
        nvec++; if (bus.busy !== 1'b1 || bus.out_payload !== 32'hC1) begin nerr++; $display("FAIL waw_setwins got %b/%h exp 1/c1", bus.busy, bus.out_payload); end
        idle();
        bus.in_valid = 1'b1; bus.in_rs1 = 5'd7; bus.in_use_rs1 = 1'b1;
        #1;
        nvec++; if (bus.in_ready !== 1'b0) begin nerr++; $display("FAIL waw_still_held got %b exp 0", bus.in_ready); end
        idle();
        bus.wb_valid = 1'b1; bus.wb_sel = 5'd7; bus.wb_data = 32'h78;
        tick();
        idle();
        #1;
        nvec++; if (bus.busy !== 1'b0) begin nerr++; $display("FAIL waw_drain got %b exp 0", bus.busy); end
        tick();
    endtask

    task automatic test_backpressure();
        idle();
        bus.in_valid = 1'b1; bus.in_rs1 = 5'd1; bus.in_use_rs1 = 1'b1; bus.in_payload = 32'hD1;
        tick();
        bus.out_ready = 1'b0; bus.in_payload = 32'hD2; bus.in_rs1 = 5'd2;
        for (int i = 0; i < 4; i++) begin
            #1;
            nvec++; if (bus.in_ready !== 1'b0) begin nerr++; $display("FAIL bp_ready[%0d] got %b exp 0", i, bus.in_ready); end
            nvec++; if (bus.out_valid !== 1'b1 || bus.out_payload !== 32'hD1 || bus.out_op1 !== regs[1]) begin
                nerr++; $display("FAIL bp_hold[%0d] got %b/%h/%h exp 1/d1/%h", i, bus.out_valid, bus.out_payload, bus.out_op1, regs[1]); end
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        nvec++; if (bus.in_ready !== 1'b1) begin nerr++; $display("FAIL bp_release got %b exp 1", bus.in_ready); end
        tick();
        nvec++; if (bus.out_valid !== 1'b1 || bus.out_payload !== 32'hD2 || bus.out_op1 !== regs[2]) begin
            nerr++; $display("FAIL bp_b2b got %b/%h/%h exp 1/d2/%h", bus.out_valid, bus.out_payload, bus.out_op1, regs[2]); end
        idle();
        tick();
        nvec++; if (bus.out_valid !== 1'b0) begin nerr++; $display("FAIL bp_drain got %b exp 0", bus.out_valid); end
    endtask

    task automatic test_async_reset();
        idle();
        bus.in_valid = 1'b1; bus.in_rd = 5'd3; bus.in_rd_wen = 1'b1; bus.in_payload = 32'hE0;
        tick();
        idle();
        bus.out_ready = 1'b0;
        #1;
        nvec++; if (bus.out_valid !== 1'b1 || bus.busy !== 1'b1) begin nerr++; $display("FAIL ar_setup got %b/%b exp 1/1", bus.out_valid, bus.busy); end
        #2;
        rst = 1'b0;
        #1;
        nvec++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin nerr++; $display("FAIL ar_immediate got %b/%b exp 0/0", bus.out_valid, bus.busy); end
        nvec++; if (bus.out_payload !== 32'h0 || bus.out_rd !== 5'd0) begin nerr++; $display("FAIL ar_regs got %h/%0d exp 0/0", bus.out_payload, bus.out_rd); end
        tick();
        rst = 1'b1;
        idle();
    endtask

    task automatic test_random();
        bit          msb [32];
        logic        mov, mwen, ebusy, erdy, h1, h2, hw, w1, w2, wd, wa;
        logic [31:0] mop1, mop2, mpl, nop1, nop2;
        logic [4:0]  mrd;
        for (int r = 0; r < 32; r++) msb[r] = 1'b0;
        mov = 1'b0; mwen = 1'b0; mop1 = '0; mop2 = '0; mpl = '0; mrd = '0;
        for (int c = 0; c < 500; c++) begin
            bus.in_valid   = ($urandom_range(0, 3) != 0);
            bus.in_rs1     = 5'($urandom_range(0, 7));
            bus.in_rs2     = 5'($urandom_range(0, 7));
            bus.in_use_rs1 = ($urandom_range(0, 3) != 0);
            bus.in_use_rs2 = ($urandom_range(0, 3) != 0);
            bus.in_rd      = 5'($urandom_range(0, 7));
            bus.in_rd_wen  = 1'($urandom_range(0, 1));
            bus.in_payload = $urandom;
            bus.out_ready  = ($urandom_range(0, 3) != 0);
            bus.wb_valid   = ($urandom_range(0, 2) == 0);
            bus.wb_sel     = 5'($urandom_range(0, 7));
            for (int r = 1; r < 32; r++)
                if (msb[r] && $urandom_range(0, 2) == 0) bus.wb_sel = 5'(r);
            bus.wb_data    = $urandom;
            #1;
            wa = bus.wb_valid && bus.wb_sel != 5'd0;
            w1 = wa && bus.wb_sel == bus.in_rs1;
            w2 = wa && bus.wb_sel == bus.in_rs2;
            wd = wa && bus.wb_sel == bus.in_rd;
            h1 = bus.in_use_rs1 && bus.in_rs1 != 0 && msb[bus.in_rs1] && !w1;
            h2 = bus.in_use_rs2 && bus.in_rs2 != 0 && msb[bus.in_rs2] && !w2;
            hw = bus.in_rd_wen && bus.in_rd != 0 && msb[bus.in_rd] && !wd;
            erdy = (!mov || bus.out_ready) && !(h1 || h2 || hw);
            ebusy = 1'b0;
            for (int r = 0; r < 32; r++) ebusy |= msb[r];
            nvec++; if (bus.in_ready !== erdy) begin nerr++; $display("FAIL rnd_ready[%0d] got %b exp %b", c, bus.in_ready, erdy); end
            nvec++; if (bus.out_valid !== mov) begin nerr++; $display("FAIL rnd_valid[%0d] got %b exp %b", c, bus.out_valid, mov); end
            nvec++; if (bus.busy !== ebusy) begin nerr++; $display("FAIL rnd_busy[%0d] got %b exp %b", c, bus.busy, ebusy); end
            if (mov) begin
                nvec++;
                if (bus.out_op1 !== mop1 || bus.out_op2 !== mop2 || bus.out_payload !== mpl || bus.out_rd !== mrd || bus.out_rd_wen !== mwen) begin
                    nerr++; $display("FAIL rnd_bundle[%0d] got %h/%h/%h/%0d/%b exp %h/%h/%h/%0d/%b", c,
                        bus.out_op1, bus.out_op2, bus.out_payload, bus.out_rd, bus.out_rd_wen, mop1, mop2, mpl, mrd, mwen);
                end
            end
            nop1 = (bus.in_use_rs1 && bus.in_rs1 != 0) ? (w1 ? bus.wb_data : regs[bus.in_rs1]) : 32'h0;
            nop2 = (bus.in_use_rs2 && bus.in_rs2 != 0) ? (w2 ? bus.wb_data : regs[bus.in_rs2]) : 32'h0;
            if (wa) msb[bus.wb_sel] = 1'b0;
            if (bus.in_valid && erdy) begin
                mov = 1'b1; mop1 = nop1; mop2 = nop2; mpl = bus.in_payload;
                mrd = bus.in_rd; mwen = bus.in_rd_wen;
                if (bus.in_rd_wen && bus.in_rd != 0) msb[bus.in_rd] = 1'b1;
            end else if (bus.out_ready) begin
                mov = 1'b0;
            end
            tick();
        end
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        for (int r = 0; r < 32; r++) regs[r] = (r == 0) ? 32'h0 : 32'(r * 32'h11);
        test_reset();
        test_raw();
        test_x0();
        test_waw();
        test_backpressure();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
